cache_control: RTL

- Controller for the direct-mapped, write-back, write-allocate L1 cache. The cache geometry is 8 lines x 128 bits.
- Sits between the LC-3b datapath memory port and physical memory.
- Drives the 8-entry 128-bit data array: load, 3-bit index, write data in. Consumes the array's combinational read data.
- Owns tag, valid and dirty state for all 8 lines.

---
 rtl/cache_control.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module   : cache_control
// Brief    : Controller for an 8-line x 128-bit direct-mapped, write-back,
//            write-allocate L1 cache between the CPU port and physical memory.
//            Owns the tag/valid/dirty state and drives the external data array.
// Revision : 1.0 - initial release
// ============================================================================
module cache_control (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         data_load,
  output logic [2:0]   data_index,
  output logic [127:0] data_in,
  input  logic [127:0] data_out
);

  localparam logic [1:0] S_CHECK     = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      valid_q, valid_d;
  logic [7:0]      dirty_q, dirty_d;
  logic [7:0][8:0] tag_q, tag_d;

  logic [2:0]      w_idx;
  logic [2:0]      w_word;
  logic [8:0]      w_tag;
  logic            w_req;
  logic            w_hit;
  logic [127:0]    w_merged;
  logic            w_unused;

  assign w_idx    = mem_address[6:4];
  assign w_word   = mem_address[3:1];
  assign w_tag    = mem_address[15:7];
  assign w_req    = mem_read | mem_write;
  assign w_hit    = valid_q[w_idx] & (tag_q[w_idx] == w_tag);
  // Byte addressing is resolved to 16-bit words; bit 0 carries no information.
  assign w_unused = mem_address[0];

  // Write-hit line: current line with the selected word's enabled bytes replaced.
  always_comb begin
    w_merged = data_out;
    if (mem_byte_enable[0]) w_merged[{w_word, 4'b0000} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) w_merged[{w_word, 4'b1000} +: 8] = mem_wdata[15:8];
  end

  // Next-state, bookkeeping updates and all output strobes; everything forced low in reset.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    mem_resp     = 1'b0;
    mem_rdata    = data_out[{w_word, 4'b0000} +: 16];
    pmem_address = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = 128'h0;
    data_load    = 1'b0;
    data_in      = 128'h0;
    data_index   = w_idx;

    case (state_q)
      S_CHECK: begin
        if (w_req) begin
          if (w_hit) begin
            mem_resp = 1'b1;
            // A simultaneous read+write is serviced as a write.
            if (mem_write) begin
              data_load      = 1'b1;
              data_in        = w_merged;
              dirty_d[w_idx] = 1'b1;
            end
          end else if (valid_q[w_idx] && dirty_q[w_idx]) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[w_idx], w_idx, 4'b0000};
        pmem_wdata   = data_out;
        if (pmem_resp) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {w_tag, w_idx, 4'b0000};
        if (pmem_resp) begin
          data_load      = 1'b1;
          data_in        = pmem_rdata;
          tag_d[w_idx]   = w_tag;
          valid_d[w_idx] = 1'b1;
          dirty_d[w_idx] = 1'b0;
          state_d        = S_CHECK;
        end
      end
      default: state_d = S_CHECK;
    endcase

    if (!reset_n) begin
      mem_resp     = 1'b0;
      mem_rdata    = 16'h0000;
      pmem_address = 16'h0000;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_wdata   = 128'h0;
      data_load    = 1'b0;
      data_in      = 128'h0;
      data_index   = 3'd0;
    end
  end

  // State and per-line tag/valid/dirty registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CHECK;
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

endmodule
`default_nettype wire
